branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer side of the branch compare result in the OoO core.
- Accepts resolved branches from the branch execute stage: the comparator's taken answer plus the computed target.
- Checks each resolution against the front-end prediction and trains a 2-bit saturating BHT.
- On a mispredict, raises a registered redirect/flush request to fetch and the ROB, and holds it until acknowledged.

Parameters:
- BHT_IDX_W, 6: log2 of BHT entries (64 entries x 2 bits).
- TAG_W, 4: ROB tag width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Asynchronous, active-high.
- res_valid, input, 1: resolved branch presented.
- res_ready, output, 1: unit can accept a resolution.
- res_pc, input, 32: PC of the branch.
- res_taken, input, 1: actual outcome (comparator answer; 1 for jal/jalr).
- res_target, input, 32: computed target address.
- res_uncond, input, 1: jal/jalr. BHT is not updated.
- res_pred_taken, input, 1: direction predicted at fetch.
- res_pred_target, input, 32: next PC actually fetched after the branch.
- res_tag, input, TAG_W: ROB tag of the branch.
- pred_pc, input, 32: fetch-stage lookup PC.
- pred_taken, output, 1: BHT prediction for pred_pc (combinational).
- redirect_valid, output, 1: mispredict redirect pending.
- redirect_pc, output, 32: correct next PC.
- redirect_tag, output, TAG_W: ROB tag of the mispredicted branch; younger entries are flushed.
- redirect_ack, input, 1: fetch/ROB accepted the redirect.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - redirect_valid=0, redirect_pc=0, redirect_tag=0, res_ready=1.
  - Every BHT entry = 2'b01 (weakly not-taken).
- BHT:
  - Index = pc[BHT_IDX_W+1:2].
  - pred_taken = entry[1] of the pred_pc index; combinational read.
  - A write at the same index in the same cycle is not visible until the next cycle (read returns the old value).
- Accept: res_valid && res_ready at a rising edge.
  - No holding register for the input; the unit is never "full" except in REDIRECT.
- On accept:
  - If !res_uncond: BHT[idx] increments when res_taken, decrements otherwise, saturating at 2'b11 / 2'b00.
  - correct_pc = res_taken ? res_target : res_pc+4. The add is 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.
  - mispredict = (correct_pc != res_pred_target). This covers both direction and target errors.
- FSM states:
  - IDLE: res_ready=1, redirect_valid=0. Accept with mispredict: register redirect_pc=correct_pc, redirect_tag=res_tag, go to REDIRECT. Accept without mispredict: stay in IDLE.
  - REDIRECT: res_ready=0, redirect_valid=1, redirect_pc/tag held stable. redirect_ack at an edge returns to IDLE; res_ready=1 from the following cycle.
- Latency: redirect_valid asserts in the cycle after acceptance (1 cycle). Minimum REDIRECT residency is 1 cycle (ack in the first cycle).
- redirect_ack in IDLE is ignored.
- res_valid while in REDIRECT is not accepted. The producer holds it. There is no BHT update for it.
- Back-to-back correct resolutions are accepted every cycle.

Optional Feature:
- Macro BRU_STATS_EN.
- When defined, adds outputs stat_resolved (32) and stat_mispredict (32):
  - Free-running counters incremented on each accept and each accepted mispredict.
  - Wrap at 2^32. Reset to 0.
  - A mispredict accept increments both counters in the same edge.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then read pred_pc=0x100 -> pred_taken=0. Three taken conditional resolutions at res_pc=0x100 with correct pred_target -> BHT goes 01->10->11->11, pred_taken=1 from the cycle after the first update, no redirect.
- Resolve res_pc=0x200, res_taken=1, res_target=0x280, res_pred_target=0x204, res_tag=5 -> next cycle redirect_valid=1, redirect_pc=0x280, redirect_tag=5, res_ready=0. Hold without ack for 4 cycles -> values stable.
- While in REDIRECT, drive res_valid=1 for a different branch -> not accepted, BHT unchanged. Assert ack -> IDLE; that branch is accepted on the next edge.
- res_pc=0xFFFFFFFC, res_taken=0, res_pred_target=0x0 -> no mispredict. Same with res_pred_target=0x10 -> redirect_pc=0x00000000.
- jal: res_uncond=1, taken, target=0x400, res_pred_target=0x400 -> no redirect, BHT entry unchanged.
- Assert rst mid-REDIRECT (asynchronously, between edges) -> redirect_valid drops immediately, res_ready=1, trained entry reads back pred_taken=0. With BRU_STATS_EN: 5 accepts including 2 mispredicts -> stat_resolved=5, stat_mispredict=2.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Resolution, prediction-lookup and redirect signals of the branch resolve unit.
// The producer/fetch/ROB side uses the master modport; the unit uses slave.
interface branch_resolve_if #(
  parameter int TAG_W = 4
);
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_uncond;
  logic             res_pred_taken;
  logic [31:0]      res_pred_target;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [TAG_W-1:0] redirect_tag;
  logic             redirect_ack;

  modport master (
    output res_valid, res_pc, res_taken, res_target, res_uncond,
           res_pred_taken, res_pred_target, res_tag, pred_pc, redirect_ack,
    input  res_ready, pred_taken, redirect_valid, redirect_pc, redirect_tag
  );

  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_uncond,
           res_pred_taken, res_pred_target, res_tag, pred_pc, redirect_ack,
    output res_ready, pred_taken, redirect_valid, redirect_pc, redirect_tag
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches against the fetch prediction, trains a 2-bit BHT and
// raises a held redirect on mispredict. Optional counters: BRU_STATS_EN.
//
// state    | meaning
// IDLE     | accepting resolutions, no redirect pending
// REDIRECT | mispredict redirect held until redirect_ack
module branch_resolve_unit #(
  parameter int BHT_IDX_W = 6,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispredict
`endif
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [TAG_W-1:0] redirect_tag_q, redirect_tag_d;
  logic [1:0]       bht_q [BHT_N];
  logic [1:0]       bht_d [BHT_N];

  logic [BHT_IDX_W-1:0] res_idx;
  logic [BHT_IDX_W-1:0] pred_idx;
  logic                 accept;
  logic [31:0]          correct_pc;
  logic                 mispredict;

  assign res_idx    = bus.res_pc[BHT_IDX_W+1:2];
  assign pred_idx   = bus.pred_pc[BHT_IDX_W+1:2];
  assign accept     = bus.res_valid && (state_q == IDLE);
  assign correct_pc = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
  // Comparing the full next PC catches direction and target errors alike.
  assign mispredict = (correct_pc != bus.res_pred_target);

  assign bus.res_ready      = (state_q == IDLE);
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.redirect_tag   = redirect_tag_q;
  assign bus.pred_taken     = bht_q[pred_idx][1];

  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    redirect_tag_d = redirect_tag_q;
    bht_d          = bht_q;

    case (state_q)
      IDLE: begin
        if (accept && mispredict) begin
          state_d        = REDIRECT;
          redirect_pc_d  = correct_pc;
          redirect_tag_d = bus.res_tag;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept && !bus.res_uncond) begin
      if (bus.res_taken) begin
        if (bht_q[res_idx] != 2'b11) bht_d[res_idx] = bht_q[res_idx] + 2'd1;
      end else begin
        if (bht_q[res_idx] != 2'b00) bht_d[res_idx] = bht_q[res_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      redirect_pc_q  <= '0;
      redirect_tag_q <= '0;
      bht_q          <= '{default: 2'b01};
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      redirect_tag_q <= redirect_tag_d;
      bht_q          <= bht_d;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  always_comb begin
    stat_resolved_d   = stat_resolved_q;
    stat_mispredict_d = stat_mispredict_q;
    if (accept) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
      if (mispredict) stat_mispredict_d = stat_mispredict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; inputs change and outputs are
// sampled on the falling edge, the DUT acts on the rising edge.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  branch_resolve_if #(.TAG_W(4)) bus ();

`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
`endif

  branch_resolve_unit #(.BHT_IDX_W(6), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BRU_STATS_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispredict (stat_mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one resolution for a single rising edge (unit must be ready).
  task automatic drive_res(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic [31:0] ptgt,
                           input logic unc, input logic [3:0] tag);
    bus.res_valid       = 1'b1;
    bus.res_pc          = pc;
    bus.res_taken       = taken;
    bus.res_target      = tgt;
    bus.res_pred_target = ptgt;
    bus.res_pred_taken  = taken;
    bus.res_uncond      = unc;
    bus.res_tag         = tag;
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.redirect_ack = 1'b1;
    @(negedge clk);
    bus.redirect_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pred_pc = 32'h100;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.res_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", bus.res_ready);
    else n_pass++;
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL reset_redir_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.redirect_pc !== 32'h0) $display("FAIL reset_redir_pc got %h exp 0", bus.redirect_pc);
    else n_pass++;
    n_checks++;
    if (bus.redirect_tag !== 4'h0) $display("FAIL reset_redir_tag got %h exp 0", bus.redirect_tag);
    else n_pass++;
    n_checks++;
    if (bus.pred_taken !== 1'b0) $display("FAIL reset_pred got %0b exp 0", bus.pred_taken);
    else n_pass++;
    rst = 1'b0;
  endtask

  // Counter walk 01->10->11->11->10->01->00->00->01->10 at index of 0x100.
  task automatic test_bht_train();
    logic tk  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.pred_pc = 32'h100;
    for (int i = 0; i < 9; i++) begin
      drive_res(32'h100, tk[i], 32'h180, tk[i] ? 32'h180 : 32'h104, 1'b0, 4'd1);
      n_checks++;
      if (bus.pred_taken !== exp[i]) $display("FAIL train_pred[%0d] got %0b exp %0b", i, bus.pred_taken, exp[i]);
      else n_pass++;
      n_checks++;
      if (bus.redirect_valid !== 1'b0) $display("FAIL train_no_redir[%0d] got %0b exp 0", i, bus.redirect_valid);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_hold();
    drive_res(32'h200, 1'b1, 32'h280, 32'h204, 1'b0, 4'd5);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.redirect_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %0b exp 1", i, bus.redirect_valid);
      else n_pass++;
      n_checks++;
      if (bus.redirect_pc !== 32'h280) $display("FAIL hold_pc[%0d] got %h exp 00000280", i, bus.redirect_pc);
      else n_pass++;
      n_checks++;
      if (bus.redirect_tag !== 4'd5) $display("FAIL hold_tag[%0d] got %0d exp 5", i, bus.redirect_tag);
      else n_pass++;
      n_checks++;
      if (bus.res_ready !== 1'b0) $display("FAIL hold_ready[%0d] got %0b exp 0", i, bus.res_ready);
      else n_pass++;
      if (i < 4) @(negedge clk);
    end
  endtask

  // Still in REDIRECT: a pending resolution at 0x304 waits for the ack.
  task automatic test_blocked_in_redirect();
    bus.pred_pc         = 32'h304;
    bus.res_valid       = 1'b1;
    bus.res_pc          = 32'h304;
    bus.res_taken       = 1'b1;
    bus.res_target      = 32'h340;
    bus.res_pred_target = 32'h340;
    bus.res_uncond      = 1'b0;
    bus.res_tag         = 4'd7;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.pred_taken !== 1'b0) $display("FAIL blocked_bht got %0b exp 0", bus.pred_taken);
    else n_pass++;
    n_checks++;
    if (bus.redirect_pc !== 32'h280) $display("FAIL blocked_pc got %h exp 00000280", bus.redirect_pc);
    else n_pass++;
    pulse_ack();
    n_checks++;
    if (bus.res_ready !== 1'b1) $display("FAIL ack_ready got %0b exp 1", bus.res_ready);
    else n_pass++;
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL ack_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.pred_taken !== 1'b0) $display("FAIL ack_edge_bht got %0b exp 0", bus.pred_taken);
    else n_pass++;
    @(negedge clk);
    bus.res_valid = 1'b0;
    n_checks++;
    if (bus.pred_taken !== 1'b1) $display("FAIL released_bht got %0b exp 1", bus.pred_taken);
    else n_pass++;
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL released_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    drive_res(32'hFFFF_FFFC, 1'b0, 32'h1234, 32'h0, 1'b0, 4'd2);
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL wrap_ok_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
    drive_res(32'hFFFF_FFFC, 1'b0, 32'h1234, 32'h10, 1'b0, 4'd9);
    n_checks++;
    if (bus.redirect_valid !== 1'b1) $display("FAIL wrap_bad_valid got %0b exp 1", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.redirect_pc !== 32'h0) $display("FAIL wrap_bad_pc got %h exp 00000000", bus.redirect_pc);
    else n_pass++;
    n_checks++;
    if (bus.redirect_tag !== 4'd9) $display("FAIL wrap_bad_tag got %0d exp 9", bus.redirect_tag);
    else n_pass++;
    pulse_ack();
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL min_res_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.res_ready !== 1'b1) $display("FAIL min_res_ready got %0b exp 1", bus.res_ready);
    else n_pass++;
    pulse_ack();
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL idle_ack_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
  endtask

  task automatic test_jal();
    bus.pred_pc = 32'h308;
    drive_res(32'h308, 1'b1, 32'h400, 32'h400, 1'b1, 4'd3);
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL jal_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.pred_taken !== 1'b0) $display("FAIL jal_bht got %0b exp 0", bus.pred_taken);
    else n_pass++;
  endtask

  // Index of 0x100 is saturated at 11 here (0x200 shares the index).
  task automatic test_async_reset();
    bus.pred_pc = 32'h100;
    drive_res(32'h100, 1'b1, 32'h180, 32'h104, 1'b0, 4'd4);
    n_checks++;
    if (bus.redirect_valid !== 1'b1) $display("FAIL pre_rst_valid got %0b exp 1", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.pred_taken !== 1'b1) $display("FAIL pre_rst_bht got %0b exp 1", bus.pred_taken);
    else n_pass++;
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_resolved !== 32'd15) $display("FAIL pre_rst_resolved got %0d exp 15", stat_resolved);
    else n_pass++;
    n_checks++;
    if (stat_mispredict !== 32'd3) $display("FAIL pre_rst_mispredict got %0d exp 3", stat_mispredict);
    else n_pass++;
`endif
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", bus.redirect_valid);
    else n_pass++;
    n_checks++;
    if (bus.res_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", bus.res_ready);
    else n_pass++;
    n_checks++;
    if (bus.pred_taken !== 1'b0) $display("FAIL rst_bht got %0b exp 0", bus.pred_taken);
    else n_pass++;
    n_checks++;
    if (bus.redirect_pc !== 32'h0) $display("FAIL rst_pc got %h exp 00000000", bus.redirect_pc);
    else n_pass++;
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_resolved !== 32'd0) $display("FAIL rst_resolved got %0d exp 0", stat_resolved);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    drive_res(32'h500, 1'b0, 32'h600, 32'h504, 1'b0, 4'd1);
    drive_res(32'h500, 1'b1, 32'h600, 32'h504, 1'b0, 4'd2);
    pulse_ack();
    drive_res(32'h500, 1'b0, 32'h600, 32'h504, 1'b0, 4'd3);
    drive_res(32'h500, 1'b0, 32'h600, 32'h600, 1'b0, 4'd4);
    pulse_ack();
    drive_res(32'h500, 1'b1, 32'h600, 32'h600, 1'b0, 4'd5);
    n_checks++;
    if (stat_resolved !== 32'd5) $display("FAIL stat_resolved got %0d exp 5", stat_resolved);
    else n_pass++;
    n_checks++;
    if (stat_mispredict !== 32'd2) $display("FAIL stat_mispredict got %0d exp 2", stat_mispredict);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks            = 0;
    n_pass              = 0;
    rst                 = 1'b1;
    bus.res_valid       = 1'b0;
    bus.res_pc          = '0;
    bus.res_taken       = 1'b0;
    bus.res_target      = '0;
    bus.res_uncond      = 1'b0;
    bus.res_pred_taken  = 1'b0;
    bus.res_pred_target = '0;
    bus.res_tag         = '0;
    bus.pred_pc         = '0;
    bus.redirect_ack    = 1'b0;

    test_reset();
    test_bht_train();
    test_redirect_hold();
    test_blocked_in_redirect();
    test_pc_wrap();
    test_jal();
    test_async_reset();
`ifdef BRU_STATS_EN
    test_stats();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
